// File: rtl/serdes_lvds_lane_array_if.sv
// Lane-array bus bundle: tx request/data, serial pins, rx results.
// master drives requests and rx pins; slave is the lane array.
interface serdes_lvds_lane_array_if #(
    parameter int LANES  = 23,
    parameter int DATA_W = 8
);
    logic [LANES-1:0]        start_i;
    logic [LANES-1:0]        st_flag_i;
    logic [LANES*DATA_W-1:0] data_i;
    logic [LANES-1:0]        lvds_busy;
    logic [LANES-1:0]        serial_o;
    logic [LANES-1:0]        serial_i;
    logic                    loopback_i;
    logic [LANES-1:0]        valid_o;
    logic [LANES-1:0]        st_flag_o;
    logic [LANES*DATA_W-1:0] data_o;
    logic [LANES-1:0]        frame_err_o;

    modport master (
        output start_i, st_flag_i, data_i, serial_i, loopback_i,
        input  lvds_busy, serial_o, valid_o, st_flag_o, data_o,
        input  frame_err_o
    );

    modport slave (
        input  start_i, st_flag_i, data_i, serial_i, loopback_i,
        output lvds_busy, serial_o, valid_o, st_flag_o, data_o,
        output frame_err_o
    );
endinterface

// File: rtl/serdes_lvds_lane_array.sv
// N-lane framed serializer/deserializer with optional even parity,
// runtime loopback and per-lane framing-error pulses.
module serdes_lvds_lane_array #(
    parameter int LANES       = 23,
    parameter int DATA_W      = 8,
    parameter int PARITY_EN   = 0,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset,
    serdes_lvds_lane_array_if.slave bus
);
    localparam int L   = DATA_W + 3 + PARITY_EN;
    localparam int FW  = L - 1;
    localparam int RW  = DATA_W + 1 + PARITY_EN;
    localparam int TCW = $clog2(L);
    localparam int RCW = $clog2(RW);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] tx_data;
        logic              tx_flag;
        logic [FW-1:0]     tx_load;
        logic [FW-1:0]     tx_sh;
        logic [TCW-1:0]    tx_cnt;
        logic              tx_busy;
        logic              tx_line;

        assign tx_data = bus.data_i[k*DATA_W +: DATA_W];
        assign tx_flag = bus.st_flag_i[k];

        // Shifted out LSB first after the start bit; stop bit on top.
        if (PARITY_EN != 0) begin : g_tx_par
            assign tx_load = {1'b1, ^{tx_flag, tx_data}, tx_data, tx_flag};
        end else begin : g_tx_nopar
            assign tx_load = {1'b1, tx_data, tx_flag};
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                tx_sh   <= '0;
                tx_cnt  <= '0;
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else if (!tx_busy) begin
                if (bus.start_i[k]) begin
                    tx_sh   <= tx_load;
                    tx_cnt  <= '0;
                    tx_busy <= 1'b1;
                    tx_line <= 1'b0;
                end
            end else if (tx_cnt == TCW'(L - 1)) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                tx_line <= tx_sh[0];
                tx_sh   <= tx_sh >> 1;
                tx_cnt  <= tx_cnt + TCW'(1);
            end
        end

        assign bus.lvds_busy[k] = tx_busy;
        assign bus.serial_o[k]  = tx_line;

        logic                   rx_raw;
        logic [SYNC_STAGES-1:0] sync;
        logic                   rx_bit;

        assign rx_raw = bus.loopback_i ? tx_line : bus.serial_i[k];
        assign rx_bit = sync[SYNC_STAGES-1];

        // Reset to idle-high so the line never looks like a start bit.
        always_ff @(posedge clk) begin
            if (reset) sync <= '1;
            else       sync <= SYNC_STAGES'({sync, rx_raw});
        end

        rx_state_t         rx_state;
        rx_state_t         rx_next;
        logic [RCW-1:0]    rx_cnt;
        logic [RW-1:0]     rx_sh;
        logic              par_ok;
        logic              frame_ok;
        logic              shift_en;
        logic              word_ok;
        logic              word_bad;
        logic              rx_valid;
        logic              rx_err;
        logic              rx_flag;
        logic [DATA_W-1:0] rx_data;

        if (PARITY_EN != 0) begin : g_rx_par
            assign par_ok = ~^rx_sh;
        end else begin : g_rx_nopar
            assign par_ok = 1'b1;
        end

        assign frame_ok = rx_bit && par_ok;

        always_ff @(posedge clk) begin
            if (reset) rx_state <= RX_IDLE;
            else       rx_state <= rx_next;
        end

        always_comb begin
            rx_next = rx_state;
            unique case (rx_state)
                RX_IDLE:  if (!rx_bit) rx_next = RX_SHIFT;
                RX_SHIFT: if (rx_cnt == RCW'(RW - 1)) rx_next = RX_STOP;
                RX_STOP:  rx_next = frame_ok ? RX_IDLE : RX_BREAK;
                RX_BREAK: if (rx_bit) rx_next = RX_IDLE;
                default:  rx_next = RX_IDLE;
            endcase
        end

        always_comb begin
            shift_en = 1'b0;
            word_ok  = 1'b0;
            word_bad = 1'b0;
            unique case (1'b1)
                rx_state == RX_SHIFT: shift_en = 1'b1;
                rx_state == RX_STOP: begin
                    word_ok  = frame_ok;
                    word_bad = !frame_ok;
                end
                default: ;
            endcase
        end

        // Outputs only load from a complete, checked frame.
        always_ff @(posedge clk) begin
            if (reset) begin
                rx_cnt   <= '0;
                rx_sh    <= '0;
                rx_valid <= 1'b0;
                rx_err   <= 1'b0;
                rx_flag  <= 1'b0;
                rx_data  <= '0;
            end else begin
                rx_valid <= word_ok;
                rx_err   <= word_bad;
                if (rx_state == RX_IDLE) rx_cnt <= '0;
                if (shift_en) begin
                    rx_sh  <= {rx_bit, rx_sh[RW-1:1]};
                    rx_cnt <= rx_cnt + RCW'(1);
                end
                if (word_ok) begin
                    rx_flag <= rx_sh[0];
                    rx_data <= rx_sh[DATA_W:1];
                end
            end
        end

        assign bus.valid_o[k]                  = rx_valid;
        assign bus.frame_err_o[k]              = rx_err;
        assign bus.st_flag_o[k]                = rx_flag;
        assign bus.data_o[k*DATA_W +: DATA_W]  = rx_data;
    end

endmodule

// File: tb/tb_serdes_lvds_lane_array.sv
// Scoreboard bench: no-parity loopback array plus a parity-enabled
// array fed from serial_i.
module tb_serdes_lvds_lane_array;
    localparam int LN = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serdes_lvds_lane_array_if #(.LANES(LN), .DATA_W(DW)) ia ();
    serdes_lvds_lane_array_if #(.LANES(LN), .DATA_W(DW)) ip ();

    serdes_lvds_lane_array #(
        .LANES(LN), .DATA_W(DW), .PARITY_EN(0), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );

    serdes_lvds_lane_array #(
        .LANES(LN), .DATA_W(DW), .PARITY_EN(1), .SYNC_STAGES(2)
    ) dut_p (
        .clk(clk), .reset(reset), .bus(ip)
    );

    typedef struct {
        bit         err;
        bit         flag;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t qa[LN][$];
    exp_t qp[LN][$];
    bit         hold_a_f[LN];
    logic [7:0] hold_a_d[LN];
    bit         hold_p_f[LN];
    logic [7:0] hold_p_d[LN];
    exp_t ea, ep;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_a(int k, bit err, bit f, logic [7:0] d, int c);
        exp_t e;
        if (err) begin
            e = '{1'b1, hold_a_f[k], hold_a_d[k], c};
        end else begin
            e = '{1'b0, f, d, c};
            hold_a_f[k] = f;
            hold_a_d[k] = d;
        end
        qa[k].push_back(e);
    endfunction

    function automatic void push_p(int k, bit err, bit f, logic [7:0] d, int c);
        exp_t e;
        if (err) begin
            e = '{1'b1, hold_p_f[k], hold_p_d[k], c};
        end else begin
            e = '{1'b0, f, d, c};
            hold_p_f[k] = f;
            hold_p_d[k] = d;
        end
        qp[k].push_back(e);
    endfunction

    function automatic int tot_q();
        int n = 0;
        for (int k = 0; k < LN; k++) n += qa[k].size() + qp[k].size();
        return n;
    endfunction

    task automatic drain(input int maxc);
        int n = 0;
        while (tot_q() != 0 && n < maxc) begin
            tick();
            n++;
        end
        tests++;
        if (tot_q() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses missing after %0d cycles",
                     tot_q(), maxc);
            for (int k = 0; k < LN; k++) begin
                qa[k].delete();
                qp[k].delete();
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < LN; k++) begin
            if (ia.valid_o[k] || ia.frame_err_o[k]) begin
                if (qa[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_unexpected lane%0d: valid=%0b err=%0b, expected none",
                             k, ia.valid_o[k], ia.frame_err_o[k]);
                end else begin
                    ea = qa[k].pop_front();
                    chk($sformatf("a_kind_l%0d", k),
                        32'({ia.valid_o[k], ia.frame_err_o[k]}),
                        32'({~ea.err, ea.err}));
                    chk($sformatf("a_data_l%0d", k),
                        32'(ia.data_o[k*DW +: DW]), 32'(ea.data));
                    chk($sformatf("a_flag_l%0d", k),
                        32'(ia.st_flag_o[k]), 32'(ea.flag));
                    chk($sformatf("a_cycle_l%0d", k), cyc, ea.cyc);
                end
            end
            if (ip.valid_o[k] || ip.frame_err_o[k]) begin
                if (qp[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL p_unexpected lane%0d: valid=%0b err=%0b, expected none",
                             k, ip.valid_o[k], ip.frame_err_o[k]);
                end else begin
                    ep = qp[k].pop_front();
                    chk($sformatf("p_kind_l%0d", k),
                        32'({ip.valid_o[k], ip.frame_err_o[k]}),
                        32'({~ep.err, ep.err}));
                    chk($sformatf("p_data_l%0d", k),
                        32'(ip.data_o[k*DW +: DW]), 32'(ep.data));
                    chk($sformatf("p_flag_l%0d", k),
                        32'(ip.st_flag_o[k]), 32'(ep.flag));
                    chk($sformatf("p_cycle_l%0d", k), cyc, ep.cyc);
                end
            end
        end
    end

    task automatic drive_a3(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ia.serial_i[3] = b[i];
            tick();
        end
    endtask

    task automatic drive_p0(input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ip.serial_i[0] = b[i];
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [10:0] wave;
    logic [7:0]  d3 [4];
    int          c0;
    int          w0;

    initial begin
        reset = 1'b1;
        ia.start_i = '0; ia.st_flag_i = '0; ia.data_i = '0;
        ia.serial_i = '1; ia.loopback_i = 1'b1;
        ip.start_i = '0; ip.st_flag_i = '0; ip.data_i = '0;
        ip.serial_i = '1; ip.loopback_i = 1'b0;
        for (int k = 0; k < LN; k++) begin
            hold_a_f[k] = 1'b0; hold_a_d[k] = '0;
            hold_p_f[k] = 1'b0; hold_p_d[k] = '0;
        end
        repeat (3) tick();

        chk("rst_serial", 32'(ia.serial_o), 32'(4'hF));
        chk("rst_busy", 32'(ia.lvds_busy), 32'(0));
        chk("rst_valid", 32'(ia.valid_o), 32'(0));
        chk("rst_err", 32'(ia.frame_err_o), 32'(0));
        chk("rst_data", ia.data_o, 32'(0));
        chk("rst_flag", 32'(ia.st_flag_o), 32'(0));
        chk("rst_p_serial", 32'(ip.serial_o), 32'(4'hF));
        reset = 1'b0;
        repeat (2) tick();

        // Single frame, lane 0, waveform and latency
        ia.data_i[7:0] = 8'hA5;
        ia.st_flag_i[0] = 1'b0;
        ia.start_i[0] = 1'b1;
        c0 = cyc;
        push_a(0, 1'b0, 1'b0, 8'hA5, c0 + 14);
        tick();
        ia.start_i[0] = 1'b0;
        wave = 11'b11010010100;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t1_serial_c%0d", i + 1),
                32'(ia.serial_o[0]), 32'(wave[i]));
            chk($sformatf("t1_busy_c%0d", i + 1),
                32'(ia.lvds_busy[0]), 32'(1));
            tick();
        end
        chk("t1_busy_drop", 32'(ia.lvds_busy[0]), 32'(0));
        chk("t1_idle_high", 32'(ia.serial_o[0]), 32'(1));
        drain(40);

        // Flag word on lane 2
        ia.data_i[23:16] = 8'h7E;
        ia.st_flag_i[2] = 1'b1;
        ia.start_i[2] = 1'b1;
        push_a(2, 1'b0, 1'b1, 8'h7E, cyc + 14);
        tick();
        ia.start_i[2] = 1'b0;
        ia.st_flag_i[2] = 1'b0;
        drain(40);
        chk("t2_flag_l2", 32'(ia.st_flag_o[2]), 32'(1));
        chk("t2_data_l2", 32'(ia.data_o[23:16]), 32'(8'h7E));
        chk("t2_data_l0", 32'(ia.data_o[7:0]), 32'(8'hA5));
        chk("t2_data_l1", 32'(ia.data_o[15:8]), 32'(0));

        // start held on lane 1, data changes after each accept
        d3[0] = 8'h3C; d3[1] = 8'hC3; d3[2] = 8'h55; d3[3] = 8'h0F;
        ia.data_i[15:8] = d3[0];
        ia.start_i[1] = 1'b1;
        c0 = cyc;
        push_a(1, 1'b0, 1'b0, d3[0], c0 + 14);
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk($sformatf("t3_busy_c%0d", i),
                32'(ia.lvds_busy[1]), 32'(i % 12 != 0));
            if (i == 1 || i == 13 || i == 25) begin
                ia.data_i[15:8] = d3[(i - 1) / 12 + 1];
                push_a(1, 1'b0, 1'b0, d3[(i - 1) / 12 + 1], c0 + i + 25);
            end
            if (i == 37) ia.data_i[15:8] = 8'hEE;
            if (i == 40) ia.start_i[1] = 1'b0;
        end
        drain(60);

        // All lanes in the same cycle
        ia.data_i = 32'h44332211;
        ia.st_flag_i = 4'b1010;
        ia.start_i = 4'hF;
        c0 = cyc;
        push_a(0, 1'b0, 1'b0, 8'h11, c0 + 14);
        push_a(1, 1'b0, 1'b1, 8'h22, c0 + 14);
        push_a(2, 1'b0, 1'b0, 8'h33, c0 + 14);
        push_a(3, 1'b0, 1'b1, 8'h44, c0 + 14);
        tick();
        ia.start_i = '0;
        ia.st_flag_i = '0;
        drain(40);

        // Bad stop bit on external lane 3, stuck low, then recovery
        ia.loopback_i = 1'b0;
        repeat (2) tick();
        w0 = cyc;
        push_a(3, 1'b1, 1'b0, 8'h00, w0 + 13);
        drive_a3({5'b0, 1'b0, 8'h99, 1'b0, 1'b0}, 11);
        ia.serial_i[3] = 1'b0;
        repeat (20) tick();
        ia.serial_i[3] = 1'b1;
        repeat (3) tick();
        chk("t4_pending", 32'(qa[3].size()), 32'(0));
        chk("t4_data_held", 32'(ia.data_o[31:24]), 32'(8'h44));
        w0 = cyc;
        push_a(3, 1'b0, 1'b1, 8'h5A, w0 + 13);
        drive_a3({5'b0, 1'b1, 8'h5A, 1'b1, 1'b0}, 11);
        ia.serial_i[3] = 1'b1;
        drain(40);
        ia.loopback_i = 1'b1;
        repeat (2) tick();

        // Reset in the middle of a frame
        ia.data_i[7:0] = 8'hFF;
        ia.start_i[0] = 1'b1;
        tick();
        ia.start_i[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("t6_serial", 32'(ia.serial_o), 32'(4'hF));
        chk("t6_busy", 32'(ia.lvds_busy), 32'(0));
        chk("t6_valid", 32'(ia.valid_o), 32'(0));
        chk("t6_data", ia.data_o, 32'(0));
        reset = 1'b0;
        for (int k = 0; k < LN; k++) begin
            hold_a_f[k] = 1'b0; hold_a_d[k] = '0;
            hold_p_f[k] = 1'b0; hold_p_d[k] = '0;
        end
        repeat (30) tick();
        chk("t6_quiet_busy", 32'(ia.lvds_busy), 32'(0));

        // Parity instance: good, flipped parity, good
        w0 = cyc;
        push_p(0, 1'b0, 1'b0, 8'h01, w0 + 14);
        drive_p0({4'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0}, 12);
        ip.serial_i[0] = 1'b1;
        drain(40);
        w0 = cyc;
        push_p(0, 1'b1, 1'b0, 8'h00, w0 + 14);
        drive_p0({4'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0}, 12);
        ip.serial_i[0] = 1'b1;
        drain(40);
        w0 = cyc;
        push_p(0, 1'b0, 1'b1, 8'h07, w0 + 14);
        drive_p0({4'b0, 1'b1, 1'b0, 8'h07, 1'b1, 1'b0}, 12);
        ip.serial_i[0] = 1'b1;
        drain(40);

        // Parity bit on the transmit side
        ip.data_i[15:8] = 8'h01;
        ip.st_flag_i[1] = 1'b0;
        ip.start_i[1] = 1'b1;
        tick();
        ip.start_i[1] = 1'b0;
        repeat (10) tick();
        chk("tp_parity_bit", 32'(ip.serial_o[1]), 32'(1));
        tick();
        chk("tp_stop_bit", 32'(ip.serial_o[1]), 32'(1));
        chk("tp_busy_stop", 32'(ip.lvds_busy[1]), 32'(1));
        tick();
        chk("tp_busy_drop", 32'(ip.lvds_busy[1]), 32'(0));

        drain(40);
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
